sao_param_bin_writer: RTL



---
 rtl/sao_bin_pkg.sv | 50 +++++
 rtl/sao_bin_sym_gen.sv | 38 +++
 rtl/sao_param_bin_writer.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sao_bin_pkg.sv
// Shared definitions for the SAO parameter bin writer.
//   - FSM state enum
//   - SAO type codes and CABAC context ids carried on bin_ctx
//   - symbol kinds understood by sao_bin_sym_gen
//   - captured CTU bundle struct: offsets are stored already reduced to
//     saturated magnitude + sign, so the FSM never touches raw inputs.
package sao_bin_pkg;

  localparam int OFFSET_CMAX_DFLT = 7;  // truncated-rice cMax, 8-bit video
  localparam int AUX_W            = 5;  // band position width
  localparam int ABS_W            = 3;  // holds 0..OFFSET_CMAX

  typedef enum logic [3:0] {
    IDLE,
    MRG_L,
    MRG_U,
    TYPE0,
    TYPE1,
    ABS,
    SIGN,
    BAND,
    EOCLS,
    NEXT_C
  } state_e;

  localparam logic [1:0] SAO_OFF = 2'd0;
  localparam logic [1:0] SAO_BO  = 2'd1;
  localparam logic [1:0] SAO_EO  = 2'd2;

  localparam logic [1:0] CTX_MERGE_LEFT  = 2'd0;
  localparam logic [1:0] CTX_MERGE_UP    = 2'd1;
  localparam logic [1:0] CTX_TYPE_LUMA   = 2'd2;
  localparam logic [1:0] CTX_TYPE_CHROMA = 2'd3;

  typedef enum logic {
    SYM_TR,  // truncated rice / truncated unary, cMax in len
    SYM_FL   // fixed length, MSB first, width in len
  } sym_kind_e;

  typedef struct packed {
    logic                          ml;        // effective merge-left
    logic                          mu;        // effective merge-up
    logic                          up_avail;
    logic [0:2][1:0]               typ;       // effective type per component
    logic [0:2][AUX_W-1:0]         aux;       // band position / EO class
    logic [0:2][0:3][ABS_W-1:0]    abs_v;     // saturated |offset|
    logic [0:2][0:3]               neg;       // offset < 0
  } sao_bundle_t;

endpackage

// File: rtl/sao_bin_sym_gen.sv
// Combinational bin generator for one symbol position.
//   kind     : SYM_TR (truncated unary, len = cMax) or SYM_FL (len = width)
//   value    : symbol value
//   len      : cMax (TR) or bit count (FL)
//   idx      : bin index within the symbol
//   bin_val  : value of bin idx
//   sym_last : bin idx is the final bin of the symbol
module sao_bin_sym_gen
  import sao_bin_pkg::*;
(
  input  sym_kind_e  kind,
  input  logic [4:0] value,
  input  logic [2:0] len,
  input  logic [2:0] idx,
  output logic       bin_val,
  output logic       sym_last
);

  logic [2:0] fl_pos;
  logic [4:0] fl_shift;

  always_comb begin
    fl_pos   = len - 3'd1 - idx;
    fl_shift = value >> fl_pos;
    bin_val  = 1'b0;
    sym_last = 1'b0;
    if (kind == SYM_TR) begin
      // value ones then a zero; the zero is dropped when value == cMax,
      // which makes bin cMax-1 the last one.
      bin_val  = ({2'b00, idx} < value);
      sym_last = ({2'b00, idx} >= value) || (idx == len - 3'd1);
    end else begin
      bin_val  = fl_shift[0];
      sym_last = (idx == len - 3'd1);
    end
  end

endmodule

// File: rtl/sao_param_bin_writer.sv
// SAO parameter bin writer: serialises one CTU's SAO decision into the
// HEVC SAO syntax bin stream, one bin per cycle, for the CABAC engine.
//
// Optional feature macro: SAO_CHROMA_EN
//   defined   : luma + Cb + Cr syntax (Cr shares Cb's type and EO class)
//   undefined : monochrome, CTU ends after luma; chroma inputs ignored
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid / in_ready       CTU decision bundle handshake
//   left_avail, up_avail      merge candidates available
//   merge_left, merge_up      decided merge direction
//   sao_type[0:2]             0 OFF, 1 BO, 2 EO (Cr entry ignored)
//   aux[0:2]                  band position (BO) / EO class in [1:0]
//   offset[0:2][0:3]          signed offsets
//   bin_valid / bin_ready     bin handshake
//   bin_val, bin_bypass       bin value, 1 = bypass coded
//   bin_ctx                   context id (0 when bypass)
//   bin_last                  final bin of the CTU
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. bin_valid never drops and bin outputs never change while
// bin_valid is high and bin_ready is low. in_ready is high only in IDLE.
//
// All bin outputs are decoded from registered state, so they are stable
// during a stall by construction. Component changes are resolved in the
// same cycle as the last bin of the previous component, keeping the stream
// bubble-free; NEXT_C is never entered and only exists as a safe fallback.
module sao_param_bin_writer
  import sao_bin_pkg::*;
#(
  parameter int offset_len  = 4,
  parameter int aux_len     = 5,
  parameter int OFFSET_CMAX = OFFSET_CMAX_DFLT
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic                                     left_avail,
  input  logic                                     up_avail,
  input  logic                                     merge_left,
  input  logic                                     merge_up,
  input  logic [0:2][1:0]                          sao_type,
  input  logic [0:2][aux_len-1:0]                  aux,
  input  logic signed [0:2][0:3][offset_len-1:0]   offset,
  output logic                                     bin_valid,
  input  logic                                     bin_ready,
  output logic                                     bin_val,
  output logic                                     bin_bypass,
  output logic [1:0]                               bin_ctx,
  output logic                                     bin_last
);

  localparam logic [2:0] CMAX3 = 3'(OFFSET_CMAX);

  state_e      state_q, state_d;
  logic [1:0]  comp_q, comp_d;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  ucnt_q, ucnt_d;
  logic [2:0]  fl_q, fl_d;
  sao_bundle_t bund_q, bund_d;
  sao_bundle_t cap;

  // Saturated magnitude: the most negative offset codes as cMax.
  function automatic logic [ABS_W-1:0] sat_abs(input logic [offset_len-1:0] o);
    logic [offset_len:0] mag;
    mag = o[offset_len-1] ? ({1'b0, ~o} + {{offset_len{1'b0}}, 1'b1})
                          : {1'b0, o};
    if (int'(mag) > OFFSET_CMAX) sat_abs = ABS_W'(OFFSET_CMAX);
    else                         sat_abs = ABS_W'(mag);
  endfunction

  // Lowest offset index >= from with a nonzero magnitude; 4 when none.
  function automatic logic [2:0] first_nz(input logic [0:3][ABS_W-1:0] a,
                                          input logic [2:0] from);
    first_nz = 3'd4;
    for (int i = 3; i >= 0; i--) begin
      if ((3'(i) >= from) && (a[i] != '0)) first_nz = 3'(i);
    end
  endfunction

  // Bundle reduction at capture time.
  always_comb begin
    cap          = '0;
    cap.ml       = merge_left & left_avail;
    cap.mu       = merge_up & up_avail & ~(merge_left & left_avail);
    cap.up_avail = up_avail;
    cap.typ[0]   = sao_type[0];
`ifdef SAO_CHROMA_EN
    cap.typ[1]   = sao_type[1];
    cap.typ[2]   = sao_type[1];
`endif
    for (int c = 0; c < 3; c++) begin
      cap.aux[c] = AUX_W'(aux[c]);
      for (int i = 0; i < 4; i++) begin
        cap.abs_v[c][i] = sat_abs(offset[c][i]);
        cap.neg[c][i]   = offset[c][i][offset_len-1];
      end
    end
  end

`ifdef SAO_CHROMA_EN
  logic unused_in;
  assign unused_in = ^sao_type[2];
`else
  logic unused_in;
  assign unused_in = ^{sao_type[1], sao_type[2]};
`endif

  // Symbol generator input selection (state-only, no feedback from outputs).
  sym_kind_e  sym_kind;
  logic [4:0] sym_value;
  logic [2:0] sym_len;
  logic [2:0] sym_idx;
  logic       sym_val;
  logic       sym_last;

  always_comb begin
    sym_kind  = SYM_TR;
    sym_value = {2'b00, bund_q.abs_v[comp_q][idx_q]};
    sym_len   = CMAX3;
    sym_idx   = ucnt_q;
    if (state_q == BAND) begin
      sym_kind  = SYM_FL;
      sym_value = bund_q.aux[comp_q];
      sym_len   = 3'd5;
      sym_idx   = fl_q;
    end else if (state_q == EOCLS) begin
      sym_kind  = SYM_FL;
      sym_value = {3'b000, bund_q.aux[comp_q][1:0]};
      sym_len   = 3'd2;
      sym_idx   = fl_q;
    end
  end

  sao_bin_sym_gen u_sym (
    .kind     (sym_kind),
    .value    (sym_value),
    .len      (sym_len),
    .idx      (sym_idx),
    .bin_val  (sym_val),
    .sym_last (sym_last)
  );

  // Where the stream goes after the current component finishes.
  state_e nc_state;
  logic   nc_done;

  always_comb begin
    nc_state = IDLE;
    nc_done  = 1'b1;
`ifdef SAO_CHROMA_EN
    if (comp_q == 2'd0) begin
      nc_state = TYPE0;
      nc_done  = 1'b0;
    end else if ((comp_q == 2'd1) && (bund_q.typ[2] != SAO_OFF)) begin
      nc_state = ABS;  // Cr has no type bins of its own
      nc_done  = 1'b0;
    end
`endif
  end

  state_e     nxt_state;
  logic       nxt_done;
  logic [1:0] nxt_comp;
  logic [1:0] nxt_idx;
  logic [2:0] nxt_ucnt;
  logic [2:0] nxt_fl;
  logic       go_nc;
  logic [1:0] cur_type;
  logic [2:0] nz;

  always_comb begin
    state_d    = state_q;
    comp_d     = comp_q;
    idx_d      = idx_q;
    ucnt_d     = ucnt_q;
    fl_d       = fl_q;
    bund_d     = bund_q;
    in_ready   = (state_q == IDLE);
    bin_valid  = 1'b0;
    bin_val    = 1'b0;
    bin_bypass = 1'b0;
    bin_ctx    = CTX_MERGE_LEFT;
    nxt_state  = state_q;
    nxt_done   = 1'b0;
    nxt_comp   = comp_q;
    nxt_idx    = idx_q;
    nxt_ucnt   = ucnt_q;
    nxt_fl     = fl_q;
    go_nc      = 1'b0;
    cur_type   = bund_q.typ[comp_q];
    nz         = 3'd4;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bund_d = cap;
          comp_d = 2'd0;
          idx_d  = 2'd0;
          ucnt_d = 3'd0;
          fl_d   = 3'd0;
          if (left_avail)    state_d = MRG_L;
          else if (up_avail) state_d = MRG_U;
          else               state_d = TYPE0;
        end
      end
      MRG_L: begin
        bin_valid = 1'b1;
        bin_val   = bund_q.ml;
        bin_ctx   = CTX_MERGE_LEFT;
        if (bund_q.ml)            nxt_done  = 1'b1;
        else if (bund_q.up_avail) nxt_state = MRG_U;
        else                      nxt_state = TYPE0;
      end
      MRG_U: begin
        bin_valid = 1'b1;
        bin_val   = bund_q.mu;
        bin_ctx   = CTX_MERGE_UP;
        if (bund_q.mu) nxt_done  = 1'b1;
        else           nxt_state = TYPE0;
      end
      TYPE0: begin
        bin_valid = 1'b1;
        bin_val   = (cur_type != SAO_OFF);
        bin_ctx   = (comp_q == 2'd0) ? CTX_TYPE_LUMA : CTX_TYPE_CHROMA;
        if (cur_type != SAO_OFF) nxt_state = TYPE1;
        else                     go_nc     = 1'b1;
      end
      TYPE1: begin
        bin_valid  = 1'b1;
        bin_bypass = 1'b1;
        bin_val    = (cur_type == SAO_EO);
        nxt_state  = ABS;
        nxt_idx    = 2'd0;
        nxt_ucnt   = 3'd0;
      end
      ABS: begin
        bin_valid  = 1'b1;
        bin_bypass = 1'b1;
        bin_val    = sym_val;
        if (!sym_last) begin
          nxt_ucnt = ucnt_q + 3'd1;
        end else if (idx_q != 2'd3) begin
          nxt_idx  = idx_q + 2'd1;
          nxt_ucnt = 3'd0;
        end else begin
          nxt_ucnt = 3'd0;
          nxt_fl   = 3'd0;
          if (cur_type == SAO_EO) begin
            if (comp_q != 2'd2) nxt_state = EOCLS;
            else                go_nc     = 1'b1;
          end else begin
            nz = first_nz(bund_q.abs_v[comp_q], 3'd0);
            if (nz == 3'd4) nxt_state = BAND;
            else begin
              nxt_state = SIGN;
              nxt_idx   = nz[1:0];
            end
          end
        end
      end
      SIGN: begin
        bin_valid  = 1'b1;
        bin_bypass = 1'b1;
        bin_val    = bund_q.neg[comp_q][idx_q];
        nz = first_nz(bund_q.abs_v[comp_q], {1'b0, idx_q} + 3'd1);
        if (nz == 3'd4) begin
          nxt_state = BAND;
          nxt_fl    = 3'd0;
        end else begin
          nxt_idx = nz[1:0];
        end
      end
      BAND, EOCLS: begin
        bin_valid  = 1'b1;
        bin_bypass = 1'b1;
        bin_val    = sym_val;
        if (!sym_last) nxt_fl = fl_q + 3'd1;
        else           go_nc  = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (go_nc) begin
      nxt_state = nc_state;
      nxt_done  = nc_done;
      nxt_comp  = comp_q + 2'd1;
      nxt_idx   = 2'd0;
      nxt_ucnt  = 3'd0;
      nxt_fl    = 3'd0;
    end

    bin_last = bin_valid & nxt_done;

    if (bin_valid && bin_ready) begin
      state_d = nxt_done ? IDLE : nxt_state;
      comp_d  = nxt_comp;
      idx_d   = nxt_idx;
      ucnt_d  = nxt_ucnt;
      fl_d    = nxt_fl;
      if (nxt_done) begin
        comp_d = 2'd0;
        idx_d  = 2'd0;
        ucnt_d = 3'd0;
        fl_d   = 3'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      comp_q  <= 2'd0;
      idx_q   <= 2'd0;
      ucnt_q  <= 3'd0;
      fl_q    <= 3'd0;
      bund_q  <= '0;
    end else begin
      state_q <= state_d;
      comp_q  <= comp_d;
      idx_q   <= idx_d;
      ucnt_q  <= ucnt_d;
      fl_q    <= fl_d;
      bund_q  <= bund_d;
    end
  end

endmodule
